// File: rtl/uart_pkg.sv
// Shared UART constants used by the rx/tx datapaths and the top level.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; occupancy tracking lives in the parent.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: captures strobed bytes from the UART receiver into a circular
// FIFO, serves them show-ahead over valid/ready, and flags drops with a sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_wr_valid,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic             rd_fire, wr_en, ovf_set;
  logic [WIDTH-1:0] mem_rdata;

  assign rd_fire = !empty_q && i_rd_ready;
  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign wr_en   = i_wr_valid && (!full_q || rd_fire);
  assign ovf_set = i_wr_valid && full_q && !rd_fire;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (wr_en) begin
      wp_d = wp_q + AW'(1);
    end
    if (rd_fire) begin
      rp_d = rp_q + AW'(1);
    end
    unique case ({wr_en, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CountFull);
    empty_d = (count_d == '0);
    ovf_d   = ovf_set ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (wr_en),
    .waddr_i (wp_q),
    .wdata_i (i_wr_data),
    .raddr_i (rp_q),
    .rdata_o (mem_rdata)
  );

  // Masked while empty so the unreset storage never leaks X onto the bus.
  assign o_rd_data  = empty_q ? '0 : mem_rdata;
  assign o_rd_valid = !empty_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes queue up as expected reads, a
// negedge monitor pops and compares on every read handshake.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_wr_valid;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             i_rd_ready;
  logic [4:0]       o_count;
  logic             o_full;
  logic             o_empty;
  logic             o_overflow;
  logic             i_clr_ovf;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_data  (i_wr_data),
    .i_wr_valid (i_wr_valid),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .i_clr_ovf  (i_clr_ovf)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain byte queue plus an occupancy number and a sticky flag.
  logic [WIDTH-1:0] exp_q [$];
  int               m_cnt = 0;
  bit               m_ovf = 1'b0;
  int               max_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(o_count), 32'(m_cnt));
    chk({tag, ".valid"}, 32'(o_rd_valid), 32'(m_cnt != 0));
    chk({tag, ".empty"}, 32'(o_empty), 32'(m_cnt == 0));
    chk({tag, ".full"}, 32'(o_full), 32'(m_cnt == DEPTH));
    chk({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
  endtask

  // Drive one cycle's inputs, update the model for the coming edge, check after it.
  task automatic cycle(input bit wv, input logic [WIDTH-1:0] wd, input bit rr, input bit clr,
                       input string tag);
    bit fire, acc, ovf;
    i_wr_valid = wv;
    i_wr_data  = wd;
    i_rd_ready = rr;
    i_clr_ovf  = clr;
    fire = (m_cnt != 0) && rr;
    acc  = wv && ((m_cnt < DEPTH) || fire);
    ovf  = wv && (m_cnt == DEPTH) && !fire;
    if (acc) exp_q.push_back(wd);
    m_cnt = m_cnt + (acc ? 1 : 0) - (fire ? 1 : 0);
    if (ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge i_clk);
    #1;
    chk_state(tag);
    if (m_cnt > max_cnt) max_cnt = m_cnt;
  endtask

  // Monitor: inputs settle at posedge+1, so the negedge sees this cycle's handshake.
  always @(negedge i_clk) begin
    if (o_rd_valid && i_rd_ready && i_reset) begin
      if (exp_q.size() == 0) begin
        chk("mon.unexpected_read", 32'(o_rd_data), 32'hDEAD_BEEF);
      end else begin
        chk("mon.rd_data", 32'(o_rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  logic [WIDTH-1:0] pat [3];

  initial begin
    i_reset    = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = '0;
    i_rd_ready = 1'b0;
    i_clr_ovf  = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_state("reset");
    chk("reset.rd_data_known", 32'($isunknown(o_rd_data)), 32'd0);
    i_reset = 1'b1;

    // Idle with ready held high must not underflow.
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, "idle");

    // Three spaced writes, then reads.
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'h7E;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, pat[i], 1'b0, 1'b0, "wr3");
      cycle(1'b0, '0, 1'b0, 1'b0, "wr3.gap");
    end
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, "rd3");

    // Fill, overflow, drain, clear.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, "ovf");
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, "hold");
    repeat (DEPTH) cycle(1'b0, '0, 1'b1, 1'b0, "drain");
    cycle(1'b0, '0, 1'b0, 1'b1, "clr");

    // Full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "fill2");
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "full_rw");
    repeat (DEPTH) cycle(1'b0, '0, 1'b1, 1'b0, "drain2");

    // Sustained streaming: occupancy must stay at or below one.
    max_cnt = 0;
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, "stream");
    cycle(1'b0, '0, 1'b1, 1'b0, "stream.tail");
    chk("stream.max_count", 32'(max_cnt), 32'd1);

    // Asynchronous reset with five bytes buffered.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre_rst");
    i_wr_valid = 1'b0;
    i_reset    = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    #2;
    chk("async_rst.empty", 32'(o_empty), 32'd1);
    chk("async_rst.count", 32'(o_count), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    cycle(1'b1, 8'h99, 1'b0, 1'b0, "post_rst.wr");
    cycle(1'b0, '0, 1'b1, 1'b0, "post_rst.rd");

    // Randomized traffic, including overflows and flag clears.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 19) == 0), "rand");
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0, "final_drain");
    chk("final.scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
